// File: rtl/barrido_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrido_pkg                                                          |
// | Shared types and constants for the multiplexed result display.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package barrido_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    CARGA     = 2'd2
  } estado_t;

  localparam int NUM_DIGITOS = 6;
  localparam int BITS_BCD    = 20;
  localparam int BITS_MAG    = 16;

  localparam logic [6:0] SEG_BLANCO = 7'b1111111;
  localparam logic [6:0] SEG_MENOS  = 7'b0111111;

  // Active-low cathodes {g,f,e,d,c,b,a}, entry n is the glyph for digit n
  localparam logic [9:0][6:0] TABLA_7SEG = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage
`default_nettype wire

// File: rtl/barrido_display_decodificador_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decodificador_7seg                                                   |
// | BCD digit to active-low 7-segment cathode pattern; non-BCD -> blank. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module decodificador_7seg
  import barrido_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_BLANCO;
    if (bcd <= 4'd9) begin
      segmentos = TABLA_7SEG[bcd];
    end
  end

endmodule
`default_nettype wire

// File: rtl/barrido_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrido_display                                                      |
// | Signed product -> sign + 5 BCD digits (sequential double dabble),    |
// | refresh prescaler and scan mux driving the selected digit cathodes.  |
// | Optional macro: BLANK_LEADING_ZEROS_EN blanks leading zero digits.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module barrido_display
  import barrido_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] producto,
  input  logic        producto_valido,
  output logic        ocupado,
  output logic        listo,
  output logic [2:0]  contador_actualizar,
  output logic [6:0]  segmentos
);

  localparam int                   ANCHO_PRE  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [ANCHO_PRE-1:0] c_pre_fin  = ANCHO_PRE'(REFRESH_DIV - 1);
  localparam logic [2:0]           c_scan_fin = 3'(NUM_DIGITOS - 1);
  localparam logic [3:0]           c_iter_fin = 4'(BITS_MAG - 1);
  localparam int                   NUM_BCD    = BITS_BCD / 4;

  estado_t                       r_estado;
  estado_t                       w_estado_sig;
  logic [3:0]                    r_iter;
  logic [BITS_MAG-1:0]           r_mag;
  logic [BITS_BCD-1:0]           r_bcd;
  logic [BITS_BCD-1:0]           w_bcd_aj;
  logic [BITS_BCD+BITS_MAG-1:0]  w_desp;
  logic                          r_signo_conv;
  logic [BITS_BCD-1:0]           r_digitos;
  logic                          r_signo;
  logic [ANCHO_PRE-1:0]          r_pre;
  logic [2:0]                    r_scan;
  logic [3:0]                    w_digito_sel;
  logic [6:0]                    w_seg_digito;
  logic                          w_blanco;

  // ------------------------------------------------------------------
  // Conversion FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    ocupado      = 1'b0;
    listo        = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (producto_valido) begin
          w_estado_sig = CONVIERTE;
        end
      end
      CONVIERTE: begin
        ocupado = 1'b1;
        if (r_iter == c_iter_fin) begin
          w_estado_sig = CARGA;
        end
      end
      CARGA: begin
        listo        = 1'b1;
        w_estado_sig = REPOSO;
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  // ------------------------------------------------------------------
  // Double-dabble datapath
  // ------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BCD; i++) begin : g_ajuste
    assign w_bcd_aj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                          : r_bcd[4*i +: 4];
  end

  assign w_desp = {w_bcd_aj, r_mag} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter       <= '0;
      r_mag        <= '0;
      r_bcd        <= '0;
      r_signo_conv <= 1'b0;
      r_digitos    <= '0;
      r_signo      <= 1'b0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (producto_valido) begin
            r_signo_conv <= producto[15];
            // Two's-complement negate; -32768 maps to 32768 as unsigned
            r_mag        <= producto[15] ? (~producto + 16'd1) : producto;
            r_bcd        <= '0;
            r_iter       <= '0;
          end
        end
        CONVIERTE: begin
          r_bcd  <= w_desp[BITS_BCD+BITS_MAG-1:BITS_MAG];
          r_mag  <= w_desp[BITS_MAG-1:0];
          r_iter <= r_iter + 4'd1;
        end
        CARGA: begin
          r_digitos <= r_bcd;
          r_signo   <= r_signo_conv;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Refresh prescaler and scan index
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_scan <= '0;
    end else if (r_pre == c_pre_fin) begin
      r_pre  <= '0;
      r_scan <= (r_scan == c_scan_fin) ? 3'd0 : (r_scan + 3'd1);
    end else begin
      r_pre <= r_pre + ANCHO_PRE'(1);
    end
  end

  assign contador_actualizar = r_scan;

  // ------------------------------------------------------------------
  // Scan mux and segment decode
  // ------------------------------------------------------------------
  always_comb begin
    w_digito_sel = 4'd0;
    case (r_scan)
      3'd0:    w_digito_sel = r_digitos[3:0];
      3'd1:    w_digito_sel = r_digitos[7:4];
      3'd2:    w_digito_sel = r_digitos[11:8];
      3'd3:    w_digito_sel = r_digitos[15:12];
      3'd4:    w_digito_sel = r_digitos[19:16];
      default: w_digito_sel = 4'd0;
    endcase
  end

  decodificador_7seg u_decodificador_7seg (
    .bcd       (w_digito_sel),
    .segmentos (w_seg_digito)
  );

`ifdef BLANK_LEADING_ZEROS_EN
  // w_cero_sup[i]: digit i and every more-significant digit are zero
  logic [NUM_BCD-1:1] w_cero_sup;

  always_comb begin
    w_cero_sup                = '0;
    w_cero_sup[NUM_BCD-1]     = (r_digitos[4*(NUM_BCD-1) +: 4] == 4'd0);
    for (int i = NUM_BCD - 2; i >= 1; i--) begin
      w_cero_sup[i] = w_cero_sup[i+1] & (r_digitos[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_blanco = 1'b0;
    case (r_scan)
      3'd1:    w_blanco = w_cero_sup[1];
      3'd2:    w_blanco = w_cero_sup[2];
      3'd3:    w_blanco = w_cero_sup[3];
      3'd4:    w_blanco = w_cero_sup[4];
      default: w_blanco = 1'b0;
    endcase
  end
`else
  assign w_blanco = 1'b0;
`endif

  always_comb begin
    segmentos = SEG_BLANCO;
    if (r_scan == c_scan_fin) begin
      segmentos = r_signo ? SEG_MENOS : SEG_BLANCO;
    end else if ((r_scan < c_scan_fin) && !w_blanco) begin
      segmentos = w_seg_digito;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barrido_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_barrido_display                                                   |
// | Scoreboard bench for barrido_display with REFRESH_DIV = 4.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_barrido_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] producto;
  logic        producto_valido;
  logic        ocupado;
  logic        listo;
  logic [2:0]  contador_actualizar;
  logic [6:0]  segmentos;

  int n_comp   = 0;
  int n_fallos = 0;
  int n_listo  = 0;
  logic [41:0] q_esperado [$];

  always #5 clk = ~clk;

  barrido_display #(.REFRESH_DIV(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .producto            (producto),
    .producto_valido     (producto_valido),
    .ocupado             (ocupado),
    .listo               (listo),
    .contador_actualizar (contador_actualizar),
    .segmentos           (segmentos)
  );

  always @(negedge clk) begin
    if (listo === 1'b1) n_listo++;
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_digito(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected glyphs for scan slots 0..5, slot i at bits [7*i +: 7]
  function automatic logic [41:0] modelo(input logic [15:0] v);
    int          mag;
    int          pot;
    int          d [5];
    logic [41:0] r;
    bit          cero;
    mag = v[15] ? (65536 - int'(v)) : int'(v);
    pot = 1;
    for (int i = 0; i < 5; i++) begin
      d[i] = (mag / pot) % 10;
      pot  = pot * 10;
      r[7*i +: 7] = seg_digito(d[i]);
    end
`ifdef BLANK_LEADING_ZEROS_EN
    cero = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      cero = cero && (d[i] == 0);
      if (cero) r[7*i +: 7] = 7'b1111111;
    end
`else
    cero = 1'b0;
`endif
    r[41:35] = v[15] ? 7'b0111111 : 7'b1111111;
    return r;
  endfunction

  task automatic capturar(input logic [41:0] esp, input string nombre);
    logic [6:0] visto [6];
    for (int i = 0; i < 6; i++) visto[i] = 'x;
    repeat (24) begin
      if (contador_actualizar < 3'd6) visto[contador_actualizar] = segmentos;
      ciclo();
    end
    for (int i = 0; i < 6; i++) begin
      comprobar($sformatf("%s_idx%0d", nombre, i), {25'd0, visto[i]}, {25'd0, esp[7*i +: 7]});
    end
  endtask

  // Drives one strobe; con_ruido adds ignored strobes at +5 and in CARGA
  task automatic enviar(input logic [15:0] v, input string nombre, input bit con_ruido);
    int          n;
    int          listo_ini;
    logic [41:0] esp;
    q_esperado.push_back(modelo(v));
    producto        = v;
    producto_valido = 1'b1;
    ciclo();
    producto_valido = 1'b0;
    producto        = 16'h0000;
    comprobar({nombre, "_ocupado"}, {31'd0, ocupado}, 32'd1);
    n = 1;
    while (listo !== 1'b1 && n < 40) begin
      if (con_ruido && n == 5) begin
        producto        = 16'd5;
        producto_valido = 1'b1;
      end
      ciclo();
      producto_valido = 1'b0;
      n++;
    end
    comprobar({nombre, "_latencia"}, n, 32'd17);
    if (con_ruido) begin
      producto        = 16'd5;
      producto_valido = 1'b1;
    end
    esp = (q_esperado.size() > 0) ? q_esperado.pop_front() : 'x;
    ciclo();
    producto_valido = 1'b0;
    comprobar({nombre, "_ocupado_post"}, {31'd0, ocupado}, 32'd0);
    listo_ini = n_listo;
    capturar(esp, nombre);
    comprobar({nombre, "_listo_extra"}, n_listo - listo_ini, 32'd0);
  endtask

  initial begin
    int listo_ini;
    rst_n           = 1'b0;
    producto_valido = 1'b0;
    producto        = 16'h0000;
    repeat (3) ciclo();
    rst_n = 1'b1;

    comprobar("rst_contador", {29'd0, contador_actualizar}, 32'd0);
    comprobar("rst_segmentos", {25'd0, segmentos}, {25'd0, 7'b1000000});
    comprobar("rst_ocupado", {31'd0, ocupado}, 32'd0);
    comprobar("rst_listo", {31'd0, listo}, 32'd0);

    for (int k = 1; k <= 6; k++) begin
      repeat (4) ciclo();
      comprobar($sformatf("scan_paso%0d", k), {29'd0, contador_actualizar}, k % 6);
    end

    enviar(16'd1234, "p1234", 1'b0);
    enviar(16'h8000, "m32768", 1'b0);
    enviar(16'hFFFF, "m1", 1'b0);
    enviar(16'd1234, "ruido", 1'b1);
    enviar(16'h0000, "cero", 1'b0);

    listo_ini       = n_listo;
    producto        = 16'd4321;
    producto_valido = 1'b1;
    ciclo();
    producto_valido = 1'b0;
    repeat (7) ciclo();
    rst_n = 1'b0;
    #1;
    comprobar("rstmid_ocupado", {31'd0, ocupado}, 32'd0);
    comprobar("rstmid_listo", {31'd0, listo}, 32'd0);
    comprobar("rstmid_contador", {29'd0, contador_actualizar}, 32'd0);
    comprobar("rstmid_segmentos", {25'd0, segmentos}, {25'd0, 7'b1000000});
    repeat (2) ciclo();
    rst_n = 1'b1;
    repeat (30) ciclo();
    comprobar("rstmid_sin_listo", n_listo - listo_ini, 32'd0);
    comprobar("cola_vacia", q_esperado.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fallos);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observado=timeout esperado=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
